// File: rtl/nm_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nm_link_pkg
// Description : Shared types and width helpers for the NM serial link
//               controller. Holds the per-lane FSM state encoding and the
//               functions that size the bit, divider and timeout counters.
// Revision    : 1.0 - initial release
// ============================================================================
package nm_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } nm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the value max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nm_link_chan.sv
`default_nettype none
// ============================================================================
// Module      : nm_link_chan
// Description : One NM lane. Serialises a command word MSB first onto
//               c2n_data/c2n_valid, optionally waits for a response start
//               bit on the synchronised n2c line, deserialises the response
//               and reports completion or timeout with single-cycle pulses.
// Ports       : clk, rst           - clock, async active-high reset
//               cmd_valid/norsp/data/ready - command handshake
//               rsp_valid/timeout  - completion pulses
//               rsp_data           - last captured response (held)
//               c2n_data/c2n_valid - serial command out
//               n2c_data           - serial response in (async to clk)
// Revision    : 1.0 - initial release
// ============================================================================
module nm_link_chan
  import nm_link_pkg::*;
#(
  parameter int CMD_W   = 32,
  parameter int RSP_W   = 32,
  parameter int CLK_DIV = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_norsp,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic             rsp_timeout,
  output logic [RSP_W-1:0] rsp_data,
  output logic             c2n_data,
  output logic             c2n_valid,
  input  logic             n2c_data
);

  localparam int BIT_W = cnt_width(max_int(CMD_W, RSP_W));
  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int TO_W  = cnt_width(TIMEOUT);

  localparam logic [BIT_W-1:0] CMD_LAST = BIT_W'(CMD_W - 1);
  localparam logic [BIT_W-1:0] RSP_LAST = BIT_W'(RSP_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  nm_state_e        state, state_nxt;
  logic [CMD_W-1:0] cmd_sr;
  logic [RSP_W-1:0] rsp_sr;
  logic             norsp_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             n2c_meta;
  logic             n2c_s;
  logic             div_tick;
  logic [RSP_W-1:0] rsp_shift;

  // End of one serial bit period; shared by SEND and RECV.
  assign div_tick  = (div_cnt == DIV_LAST);
  assign rsp_shift = (rsp_sr << 1) | RSP_W'(n2c_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n2c_meta <= 1'b0;
      n2c_s    <= 1'b0;
    end else begin
      n2c_meta <= n2c_data;
      n2c_s    <= n2c_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    c2n_valid   = 1'b0;
    c2n_data    = 1'b0;
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        c2n_valid = 1'b1;
        c2n_data  = cmd_sr[CMD_W-1];
        if (div_tick && (bit_cnt == CMD_LAST))
          state_nxt = norsp_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // A start bit arriving on the last timeout cycle still wins.
        if (n2c_s) begin
          state_nxt = ST_RECV;
        end else if (to_cnt == TO_LAST) begin
          rsp_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (div_tick && (bit_cnt == RSP_LAST)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_sr   <= '0;
      rsp_sr   <= '0;
      rsp_data <= '0;
      norsp_q  <= 1'b0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          div_cnt <= '0;
          to_cnt  <= '0;
          if (cmd_valid) begin
            cmd_sr  <= cmd_data;
            norsp_q <= cmd_norsp;
          end
        end
        ST_SEND: begin
          if (div_tick) begin
            div_cnt <= '0;
            cmd_sr  <= cmd_sr << 1;
            bit_cnt <= (bit_cnt == CMD_LAST) ? '0 : bit_cnt + BIT_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_WAIT: begin
          // Counter leaves WAIT at TIMEOUT-1, so it never wraps.
          to_cnt  <= to_cnt + TO_W'(1);
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        ST_RECV: begin
          // Start-bit cycle is the phase reference: sample every CLK_DIV.
          if (div_tick) begin
            div_cnt <= '0;
            rsp_sr  <= rsp_shift;
            if (bit_cnt == RSP_LAST) begin
              bit_cnt  <= '0;
              rsp_data <= rsp_shift;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nm_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nm_link_ctrl
// Description : NUM_CH independent NM serial link engines between the APB
//               register front end and the NM pads. Each lane is a separate
//               nm_link_chan; this level only slices the flattened buses.
// Ports       : PCLK, PRESET        - clock, async active-high reset
//               cmd_valid/norsp/data/ready - per-lane command handshake
//               rsp_valid/rsp_timeout - per-lane completion pulses
//               rsp_data            - per-lane last response
//               C2N_DATA/C2N_VALID  - serial command lanes
//               N2C_DATA            - serial response lanes
// Revision    : 1.0 - initial release
// ============================================================================
module nm_link_ctrl
  import nm_link_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CMD_W   = 32,
  parameter int RSP_W   = 32,
  parameter int CLK_DIV = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [NUM_CH-1:0]       cmd_valid,
  input  logic [NUM_CH-1:0]       cmd_norsp,
  input  logic [NUM_CH*CMD_W-1:0] cmd_data,
  output logic [NUM_CH-1:0]       cmd_ready,
  output logic [NUM_CH-1:0]       rsp_valid,
  output logic [NUM_CH-1:0]       rsp_timeout,
  output logic [NUM_CH*RSP_W-1:0] rsp_data,
  output logic [NUM_CH-1:0]       C2N_DATA,
  output logic [NUM_CH-1:0]       C2N_VALID,
  input  logic [NUM_CH-1:0]       N2C_DATA
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    nm_link_chan #(
      .CMD_W   (CMD_W),
      .RSP_W   (RSP_W),
      .CLK_DIV (CLK_DIV),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (PCLK),
      .rst         (PRESET),
      .cmd_valid   (cmd_valid[i]),
      .cmd_norsp   (cmd_norsp[i]),
      .cmd_data    (cmd_data[i*CMD_W +: CMD_W]),
      .cmd_ready   (cmd_ready[i]),
      .rsp_valid   (rsp_valid[i]),
      .rsp_timeout (rsp_timeout[i]),
      .rsp_data    (rsp_data[i*RSP_W +: RSP_W]),
      .c2n_data    (C2N_DATA[i]),
      .c2n_valid   (C2N_VALID[i]),
      .n2c_data    (N2C_DATA[i])
    );
  end

endmodule
`default_nettype wire
